// File: rtl/switch_debouncer_pkg.sv
// Shared constants for the switch debouncer bridge device.
// Provides the register word offsets, the CTRL bit positions and a packed
// view of the CTRL register used by the top level.
package switch_debouncer_pkg;

  // Word offsets within the device window, compared against addr[3:2].
  localparam logic [1:0] SWDB_DATA = 2'd0;
  localparam logic [1:0] SWDB_CHG  = 2'd1;
  localparam logic [1:0] SWDB_CTRL = 2'd2;

  // Bit positions inside the CTRL register.
  localparam int IE     = 0;
  localparam int FREEZE = 1;

  // Field order mirrors the bit positions above (freeze is bit 1, ie is bit 0).
  typedef struct packed {
    logic freeze;
    logic ie;
  } ctrl_t;

endpackage : switch_debouncer_pkg

// File: rtl/switch_debouncer_bit.sv
// Single-bit debounce filter.
// Ports:
//   clk, rst   - system clock, synchronous active-high reset
//   tick       - shared sample strobe, one cycle wide
//   freeze     - when high, the filter state holds and no events are raised
//   sync_i     - synchronised switch level
//   level_o    - debounced level
//   set_chg_o  - one-cycle pulse, high in the cycle whose clock edge updates level_o
module debounce_bit #(
  parameter int STABLE_N = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic freeze,
  input  logic sync_i,
  output logic level_o,
  output logic set_chg_o
);

  localparam int CW = $clog2(STABLE_N + 1);
  localparam logic [CW-1:0] STAB_LAST = CW'(STABLE_N - 1);

  logic [CW-1:0] stab;
  logic          differ;
  logic          sample;

  assign differ = (sync_i != level_o);
  assign sample = tick & ~freeze;

  // Combinational so the top can latch the change event on the same edge
  // that moves level_o.
  assign set_chg_o = sample & differ & (stab == STAB_LAST);

  // NOTE: reset is synchronous (sampled on the clock edge), and all
  // sequential state uses non-blocking assignments so every flop sees the
  // pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      stab    <= '0;
      level_o <= 1'b0;
    end else if (sample) begin
      if (!differ) begin
        // Any sample agreeing with the current level restarts the count.
        stab <= '0;
      end else if (stab == STAB_LAST) begin
        level_o <= sync_i;
        stab    <= '0;
      end else begin
        stab <= stab + CW'(1);
      end
    end
  end

endmodule : debounce_bit

// File: rtl/switch_debouncer.sv
// Debounced, interrupt-capable input port for the board slide switches.
// Ports:
//   clk, rst - system clock, synchronous active-high reset
//   raw_in   - asynchronous switch pins
//   addr     - word register select (bus addr[3:2])
//   we, be   - write strobe and byte enables
//   wdata    - write data
//   rdata    - combinational read data for addr
//   sw_out   - debounced switch levels
//   irq      - registered level interrupt (IE & |CHG)
// Registers: 0 DATA (RO), 1 CHG (W1C, per byte lane), 2 CTRL (IE, FREEZE),
// 3 reserved.
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int TICK_DIV = 50000,
  parameter int STABLE_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [1:0]       addr,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [WIDTH-1:0] sw_out,
  output logic             irq
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [WIDTH-1:0] sync_q1;
  logic [WIDTH-1:0] sync_q2;
  logic [TW-1:0]    tick_cnt;
  logic             tick;
  logic [WIDTH-1:0] chg;
  logic [WIDTH-1:0] set_vec;
  logic [WIDTH-1:0] clr_vec;
  logic [31:0]      lane_mask;
  ctrl_t            ctrl;

  // Two-flop synchroniser for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= '0;
      sync_q2 <= '0;
    end else begin
      sync_q1 <= raw_in;
      sync_q2 <= sync_q1;
    end
  end

  // Free-running sample divider; keeps counting while frozen.
  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (rst)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .STABLE_N (STABLE_N)
    ) u_bit (
      .clk       (clk),
      .rst       (rst),
      .tick      (tick),
      .freeze    (ctrl.freeze),
      .sync_i    (sync_q2[i]),
      .level_o   (sw_out[i]),
      .set_chg_o (set_vec[i])
    );
  end

  // W1C mask: a bit clears only when its own byte lane is enabled.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    lane_mask = '0;
    for (int i = 0; i < 32; i++) begin
      lane_mask[i] = wdata[i] & be[i/8];
    end
  end

  assign clr_vec = (we && addr == SWDB_CHG) ? lane_mask[WIDTH-1:0] : '0;

  // Set is applied after clear, so a same-cycle set wins.
  always_ff @(posedge clk) begin
    if (rst) chg <= '0;
    else     chg <= (chg & ~clr_vec) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
    end else if (we && addr == SWDB_CTRL && be[0]) begin
      ctrl.ie     <= wdata[IE];
      ctrl.freeze <= wdata[FREEZE];
    end
  end

  // Registered from the already-registered CHG/CTRL, hence one cycle behind.
  always_ff @(posedge clk) begin
    if (rst) irq <= 1'b0;
    else     irq <= ctrl.ie & (|chg);
  end

  always_comb begin
    rdata = '0;
    case (addr)
      SWDB_DATA: rdata = 32'(sw_out);
      SWDB_CHG:  rdata = 32'(chg);
      SWDB_CTRL: rdata = {30'b0, ctrl.freeze, ctrl.ie};
      default:   rdata = '0;
    endcase
  end

endmodule : switch_debouncer

// File: tb/tb_switch_debouncer.sv
// Directed testbench for switch_debouncer with TICK_DIV=4, STABLE_N=3.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_switch_debouncer;
  import switch_debouncer_pkg::*;

  localparam int TB_TICK_DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] raw_in;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] sw_out;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  switch_debouncer #(
    .WIDTH    (32),
    .TICK_DIV (TB_TICK_DIV),
    .STABLE_N (3)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .raw_in (raw_in),
    .addr   (addr),
    .we     (we),
    .be     (be),
    .wdata  (wdata),
    .rdata  (rdata),
    .sw_out (sw_out),
    .irq    (irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    addr  = a;
    wdata = d;
    be    = b;
    we    = 1'b1;
    cycle();
    we    = 1'b0;
    be    = '0;
    wdata = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    addr = a;
    #1;
    d = rdata;
  endtask

  // Counts edges until all bits in mask are high; returns max_cyc+1 on timeout.
  task automatic wait_rise(input logic [31:0] mask, input int max_cyc, output int n);
    n = 0;
    while ((sw_out & mask) !== mask && n <= max_cyc) begin
      cycle();
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    int n;
    int lat;
    int bad;
    int extra;
    logic seen;

    rst = 1'b1; raw_in = '1; addr = '0; we = 1'b0; be = '0; wdata = '0;

    // Reset held for three rising edges with all pins high.
    @(negedge clk);
    repeat (2) cycle();
    check("reset_sw_out", sw_out, 32'h0);
    check("reset_irq", 32'(irq), 32'h0);
    for (int a = 0; a < 4; a++) begin
      bus_read(2'(a), d);
      check($sformatf("reset_read_addr%0d", a), d, 32'h0);
    end

    rst = 1'b0;
    wait_rise(32'hFFFF_FFFF, 20, n);
    check($sformatf("reset_accept_lat=%0d", n), 32'(n <= 14), 32'd1);
    check("reset_accept_sw_out", sw_out, 32'hFFFF_FFFF);
    bus_read(SWDB_CHG, d);
    check("reset_accept_chg", d, 32'hFFFF_FFFF);
    check("reset_accept_irq_ie0", 32'(irq), 32'h0);

    // Reset mid-bounce with pins low: nothing should survive.
    raw_in = '0;
    repeat (6) cycle();
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    repeat (20) cycle();
    check("midreset_sw_out", sw_out, 32'h0);
    bus_read(SWDB_CHG, d);
    check("midreset_chg", d, 32'h0);

    // Clean edge on bit 5.
    raw_in[5] = 1'b1;
    wait_rise(32'h20, 20, n);
    check($sformatf("clean_lat=%0d", n), 32'(n >= 11 && n <= 14), 32'd1);
    check("clean_sw_out", sw_out, 32'h20);
    bus_read(SWDB_CHG, d);
    check("clean_chg", d, 32'h20);
    bus_write(SWDB_DATA, 32'h0, 4'hF);
    bus_read(SWDB_DATA, d);
    check("data_write_ignored", d, 32'h20);
    bus_write(SWDB_CHG, 32'hFFFF_FFFF, 4'hF);
    bus_read(SWDB_CHG, d);
    check("clean_chg_cleared", d, 32'h0);

    // Bounce on bit 0: toggle every 5 cycles for 40 cycles, then hold high.
    bad = 0;
    for (int t = 0; t < 40; t++) begin
      if (t % 5 == 0) raw_in[0] = ~raw_in[0];
      cycle();
      if (sw_out[0] !== 1'b0) bad++;
    end
    check("bounce_held_low_cycles", 32'(bad), 32'd0);
    raw_in[0] = 1'b1;
    wait_rise(32'h1, 20, n);
    check($sformatf("bounce_final_lat=%0d", n), 32'(n >= 11 && n <= 14), 32'd1);
    bus_read(SWDB_CHG, d);
    check("bounce_chg", d, 32'h1);
    bus_write(SWDB_CHG, 32'hFFFF_FFFF, 4'hF);

    // IRQ assertion and lane-qualified W1C.
    bus_write(SWDB_CTRL, 32'h1, 4'b0001);
    bus_read(SWDB_CTRL, d);
    check("ctrl_ie_read", d, 32'h1);
    raw_in[9] = 1'b1;
    n = 0; seen = 1'b0; d = '0;
    while (!seen && n < 20) begin
      cycle();
      n++;
      bus_read(SWDB_CHG, d);
      seen = d[9];
    end
    check("irq_chg_set", d, 32'h200);
    check("irq_not_yet", 32'(irq), 32'h0);
    cycle();
    check("irq_rise", 32'(irq), 32'h1);
    bus_write(SWDB_CHG, 32'h200, 4'b0001);
    bus_read(SWDB_CHG, d);
    check("w1c_wrong_lane", d, 32'h200);
    check("w1c_wrong_lane_irq", 32'(irq), 32'h1);
    bus_write(SWDB_CHG, 32'h200, 4'b0010);
    bus_read(SWDB_CHG, d);
    check("w1c_right_lane", d, 32'h0);
    check("w1c_irq_lag", 32'(irq), 32'h1);
    cycle();
    check("w1c_irq_fall", 32'(irq), 32'h0);

    // Collision: calibrate latency on bit 2, then replay it on bit 3 in the
    // same tick phase and land a W1C on the edge that sets CHG[3].
    raw_in[2] = 1'b1;
    wait_rise(32'h4, 20, lat);
    check($sformatf("coll_calib_lat=%0d", lat), 32'(lat >= 11 && lat <= 14), 32'd1);
    extra = (TB_TICK_DIV - (lat % TB_TICK_DIV)) % TB_TICK_DIV;
    repeat (extra) cycle();
    raw_in[3] = 1'b1;
    repeat (lat - 1) cycle();
    check("coll_pre_edge", 32'(sw_out[3]), 32'h0);
    bus_write(SWDB_CHG, 32'hC, 4'b0001);
    check("coll_aligned", 32'(sw_out[3]), 32'h1);
    bus_read(SWDB_CHG, d);
    check("coll_set_wins", d, 32'h8);

    // Freeze: filter holds while the tick keeps running.
    bus_write(SWDB_CHG, 32'hFFFF_FFFF, 4'hF);
    bus_write(SWDB_CTRL, 32'h2, 4'b0001);
    bus_write(SWDB_CTRL, 32'h3, 4'b1110);
    bus_read(SWDB_CTRL, d);
    check("ctrl_be0_gated", d, 32'h2);
    raw_in[7] = 1'b1;
    bad = 0;
    for (int t = 0; t < 20; t++) begin
      cycle();
      if (sw_out[7] !== 1'b0) bad++;
    end
    check("freeze_hold_cycles", 32'(bad), 32'd0);
    bus_read(SWDB_CHG, d);
    check("freeze_no_chg", d, 32'h0);
    bus_write(SWDB_CTRL, 32'h0, 4'b0001);
    wait_rise(32'h80, 12, n);
    check($sformatf("unfreeze_lat=%0d", n), 32'(n <= 12), 32'd1);
    bus_read(SWDB_CHG, d);
    check("unfreeze_chg", d, 32'h80);
    check("unfreeze_irq_ie0", 32'(irq), 32'h0);
    bus_read(2'd3, d);
    check("reserved_read", d, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_switch_debouncer

// File: doc/switch_debouncer.md
# switch_debouncer

Debounced, interrupt-capable input port for the board's 32 slide switches. It sits between the raw switch pins and the `Switches` device/Bridge path, and performs three jobs:
- synchronises each raw input;
- filters contact bounce using a shared sample tick and per-bit stability counters;
- latches per-bit change events.

The CPU sees it as a bridge device with four word registers. A level IRQ feeds one `HardInt_in` line.

## Interface
- `WIDTH`, 32: number of switch inputs (1..32).
- `TICK_DIV`, 50000: clk cycles per sample tick (1 ms at 50 MHz); must be ≥ 2.
- `STABLE_N`, 4: consecutive differing samples required to accept a new level; must be ≥ 1.
- `clk` input 1: system clock; single clock domain.
- `rst` input 1: synchronous, active-high reset.
- `raw_in` input WIDTH: asynchronous switch pins.
- `addr` input 2 (`[3:2]`): word register select from Bridge.
- `we` input 1: write strobe from Bridge.
- `be` input 4: byte enables for writes.
- `wdata` input 32: write data.
- `rdata` output 32: combinational read data for `addr`.
- `sw_out` output WIDTH: debounced switch levels; drives the existing switch path.
- `irq` output 1: level interrupt request.

## Operation
- **Synchroniser.** `raw_in` passes through 2 flops, giving `sync`.
- **Tick counter.** `tick_cnt` counts 0..TICK_DIV-1 and wraps. `tick` = (`tick_cnt` == TICK_DIV-1).
- **Per-bit filter.** Each bit i has a stability counter `stab[i]`, width $clog2(STABLE_N+1), evaluated on `tick` cycles only:
  - `sync[i]` == `sw_out[i]`: `stab[i]` ← 0.
  - Bits differ and `stab[i]` == STABLE_N-1: `sw_out[i]` ← `sync[i]`, `chg[i]` ← 1, `stab[i]` ← 0.
  - Bits differ otherwise: `stab[i]` ← `stab[i]`+1.
  - On non-tick cycles `stab` holds.
- **Register map** (word address `addr`):
  - 0, DATA (RO): `sw_out`, zero-extended to 32 bits.
  - 1, CHG (R/W1C): sticky change bits. A write clears bit i when `wdata[i]`=1 and byte lane `be[i/8]`=1.
  - 2, CTRL (R/W): bit0 IE, bit1 FREEZE. Bits [31:2] read 0. Written only when `be[0]`=1.
  - 3, reserved: reads 0, writes ignored.
- **FREEZE=1.** `stab` and `sw_out` hold and no new CHG bits are set. The tick counter keeps running.
- **IRQ.** `irq` = IE & |CHG, registered (one cycle after the CHG/CTRL update).
- **Writes to DATA.** Ignored.

## Timing
- **Reset values.** `sw_out`=0, CHG=0, CTRL=0, `stab`=0, `tick_cnt`=0, synchroniser flops=0, `irq`=0. `rdata` reflects these combinationally.
- **Mid-operation reset.** A reset during a bounce discards all partial counts. After reset release, switches held high are re-accepted from zero: `sw_out` rises after STABLE_N ticks and sets CHG.
- **Input latency.** A raw edge is visible in `sync` 2 cycles later. `sw_out` updates on the clock edge that ends the STABLE_N-th consecutive qualifying tick.
  - Worst case: 2 + STABLE_N·TICK_DIV cycles.
  - Best case: 2 + (STABLE_N-1)·TICK_DIV + 1 cycles.
- **Bounce.** Any tick where `sync[i]` equals `sw_out[i]` restarts bit i's count.
- **Read path.** `rdata` is combinational from `addr` with no wait states; the Bridge samples it in the same cycle.
- **Write path.** Register writes take effect on the next clock edge.
- **Set/clear collision.** If a filter event sets `chg[i]` in the same cycle a W1C write clears it, set wins and the bit reads 1.
- **IRQ timing.**
  - Deassertion: `irq` drops the cycle after the last CHG bit is cleared or IE is written to 0.
  - Assertion: `irq` rises the cycle after a CHG bit sets while IE=1.
- **Unused lanes.** Bits ≥ WIDTH of DATA/CHG read 0 and cannot be set.

## Structure
- **Shared package** (alongside other bridge-device constants): register word offsets `SWDB_DATA`=2'd0, `SWDB_CHG`=2'd1, `SWDB_CTRL`=2'd2; CTRL bit positions `IE`=0, `FREEZE`=1.
- **Sub-module `debounce_bit`.** One per input via generate.
  - Inputs: `clk`, `rst`, `tick`, `freeze`, `sync_i`.
  - Outputs: `level_o`, `set_chg_o` (1-cycle pulse).
  - Parameter: STABLE_N.
- **Top.** Tick counter, synchroniser, CHG/CTRL registers, read mux, IRQ flop.

## Test plan
Bench parameters: TICK_DIV=4, STABLE_N=3, WIDTH=32.
- **Reset.** Hold `rst`=1 for 3 cycles with `raw_in`=32'hFFFF_FFFF → `sw_out`=0, `irq`=0, reads of addr 0/1/2/3 = 0. After release, `sw_out`=32'hFFFF_FFFF within 2+12 cycles and CHG=32'hFFFF_FFFF.
- **Clean edge.** From steady 0, set `raw_in[5]`=1 → `sw_out[5]` rises between cycles 11 and 14 after the edge; CHG reads 32'h0000_0020.
- **Bounce rejection.** Toggle `raw_in[0]` every 5 cycles for 40 cycles, then hold 1 → `sw_out[0]` stays 0 until 3 clean ticks after the final edge; exactly one CHG set.
- **IRQ and W1C.**
  - Write CTRL=1, then cause a change on bit 9 → `irq`=1 one cycle after CHG sets.
  - Write CHG=32'h0000_0200 with `be`=4'b0001 → no clear (lane 1 not enabled).
  - Repeat with `be`=4'b0010 → CHG=0 and `irq`=0 on the next cycle.
- **Collision.** Issue a W1C for bit 3 in the same cycle `debounce_bit[3]` pulses `set_chg_o` → CHG[3] reads 1.
- **Freeze.** With CTRL=2'b10, change `raw_in[7]` and wait 20 cycles → `sw_out[7]` unchanged. Clear FREEZE → `sw_out[7]` updates within 12 cycles.
